// File: rtl/priority_intr_ctrl.sv
// APB-programmable priority interrupt controller.
// Offers one pending, enabled source at a time and holds it until serviced.
module priority_intr_ctrl #(
    parameter int NUM_PERIPHS = 16,
    parameter int PRIO_WIDTH  = 4,
    parameter int IDX_W       = $clog2(NUM_PERIPHS),
    parameter int ADDR_WIDTH  = IDX_W + 2
) (
    input  logic                   pclk_i,
    input  logic                   prst_i,
    input  logic [ADDR_WIDTH-1:0]  paddr_i,
    input  logic                   pwrite_i,
    input  logic                   penable_i,
    input  logic [PRIO_WIDTH-1:0]  pwdata_i,
    output logic [PRIO_WIDTH-1:0]  prdata_o,
    output logic                   pready_o,
    output logic                   perror_o,
    input  logic [NUM_PERIPHS-1:0] intr_active_i,
    output logic                   intr_valid_o,
    output logic [IDX_W-1:0]       intr_to_service_o,
    input  logic                   intr_serviced_i
);

    typedef enum logic [1:0] {
        IDLE,
        ARB,
        WAIT_SVC
    } state_t;

    localparam logic [IDX_W:0] IDX_LIM = (IDX_W+1)'(NUM_PERIPHS);

    state_t state_q, state_d;

    logic [PRIO_WIDTH-1:0]  prio_q [NUM_PERIPHS];
    logic [NUM_PERIPHS-1:0] enable_q;
    logic [NUM_PERIPHS-1:0] edge_q;
    logic [NUM_PERIPHS-1:0] pending_q;
    logic [NUM_PERIPHS-1:0] pending_d;
    logic [NUM_PERIPHS-1:0] prev_q;
    logic [NUM_PERIPHS-1:0] cand;
    logic [NUM_PERIPHS-1:0] sw_clr;
    logic [NUM_PERIPHS-1:0] svc_clr;

    logic [1:0]            bank;
    logic [IDX_W-1:0]      idx;
    logic                  idx_ok;
    logic                  wr_ok;
    logic [PRIO_WIDTH-1:0] rd_data;

    logic                  svc_done;
    logic                  found;
    logic [PRIO_WIDTH-1:0] win_prio;
    logic [IDX_W-1:0]      win_idx;
    logic                  valid_d;
    logic [IDX_W-1:0]      svc_d;

    assign bank     = paddr_i[IDX_W+1:IDX_W];
    assign idx      = paddr_i[IDX_W-1:0];
    assign idx_ok   = {1'b0, idx} < IDX_LIM;
    assign wr_ok    = penable_i & pwrite_i & idx_ok;
    assign cand     = pending_q & enable_q;
    assign svc_done = (state_q == WAIT_SVC) & intr_serviced_i;

    always_comb begin
        rd_data = '0;
        unique case (bank)
            2'b00:   rd_data    = prio_q[idx];
            2'b01:   rd_data[0] = enable_q[idx];
            2'b10:   rd_data[0] = edge_q[idx];
            default: rd_data[0] = pending_q[idx];
        endcase
    end

    always_ff @(posedge pclk_i or negedge prst_i) begin
        if (!prst_i) begin
            pready_o <= 1'b0;
            perror_o <= 1'b0;
            prdata_o <= '0;
        end else begin
            pready_o <= penable_i;
            perror_o <= penable_i & ~idx_ok;
            if (penable_i && !idx_ok) begin
                prdata_o <= '0;
            end else if (penable_i && !pwrite_i) begin
                prdata_o <= rd_data;
            end
        end
    end

    always_ff @(posedge pclk_i or negedge prst_i) begin
        if (!prst_i) begin
            prio_q   <= '{default: '0};
            enable_q <= '0;
            edge_q   <= '0;
        end else if (wr_ok) begin
            unique case (bank)
                2'b00:   prio_q[idx]   <= pwdata_i;
                2'b01:   enable_q[idx] <= pwdata_i[0];
                2'b10:   edge_q[idx]   <= pwdata_i[0];
                default: ;
            endcase
        end
    end

    always_comb begin
        sw_clr  = '0;
        svc_clr = '0;
        if (wr_ok && bank == 2'b11 && pwdata_i[0]) begin
            sw_clr[idx] = 1'b1;
        end
        if (svc_done) begin
            svc_clr[intr_to_service_o] = 1'b1;
        end
    end

    // Edge sources: a new rising edge wins over any clear in the same cycle.
    assign pending_d =
        (edge_q & ((intr_active_i & ~prev_q) |
                   (pending_q & ~(sw_clr | svc_clr)))) |
        (~edge_q & intr_active_i);

    always_ff @(posedge pclk_i or negedge prst_i) begin
        if (!prst_i) begin
            pending_q <= '0;
            prev_q    <= '0;
        end else begin
            pending_q <= pending_d;
            prev_q    <= intr_active_i;
        end
    end

    // Strict compare keeps the lowest index on equal priority.
    always_comb begin
        found    = 1'b0;
        win_prio = '0;
        win_idx  = '0;
        for (int i = 0; i < NUM_PERIPHS; i++) begin
            if (cand[i] && (!found || prio_q[i] > win_prio)) begin
                found    = 1'b1;
                win_prio = prio_q[i];
                win_idx  = IDX_W'(i);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        valid_d = intr_valid_o;
        svc_d   = intr_to_service_o;
        unique case (state_q)
            IDLE: begin
                if (|cand) state_d = ARB;
            end
            ARB: begin
                if (|cand) begin
                    state_d = WAIT_SVC;
                    valid_d = 1'b1;
                    svc_d   = win_idx;
                end else begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                    svc_d   = '0;
                end
            end
            WAIT_SVC: begin
                if (intr_serviced_i) begin
                    valid_d = 1'b0;
                    svc_d   = '0;
                    state_d = (|(cand & ~svc_clr)) ? ARB : IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
                svc_d   = '0;
            end
        endcase
    end

    always_ff @(posedge pclk_i or negedge prst_i) begin
        if (!prst_i) begin
            state_q           <= IDLE;
            intr_valid_o      <= 1'b0;
            intr_to_service_o <= '0;
        end else begin
            state_q           <= state_d;
            intr_valid_o      <= valid_d;
            intr_to_service_o <= svc_d;
        end
    end

endmodule

// File: tb/tb_priority_intr_ctrl.sv
// Directed bench for priority_intr_ctrl with 12 sources.
// Expected values are hand-computed against the register map and FSM timing.
module tb_priority_intr_ctrl;

    localparam int NP = 12;
    localparam int PW = 4;
    localparam int IW = 4;
    localparam int AW = 6;

    logic          pclk_i = 1'b0;
    logic          prst_i;
    logic [AW-1:0] paddr_i;
    logic          pwrite_i;
    logic          penable_i;
    logic [PW-1:0] pwdata_i;
    logic [PW-1:0] prdata_o;
    logic          pready_o;
    logic          perror_o;
    logic [NP-1:0] intr_active_i;
    logic          intr_valid_o;
    logic [IW-1:0] intr_to_service_o;
    logic          intr_serviced_i;

    int checks = 0;
    int errors = 0;

    priority_intr_ctrl #(
        .NUM_PERIPHS(NP),
        .PRIO_WIDTH (PW)
    ) dut (
        .pclk_i           (pclk_i),
        .prst_i           (prst_i),
        .paddr_i          (paddr_i),
        .pwrite_i         (pwrite_i),
        .penable_i        (penable_i),
        .pwdata_i         (pwdata_i),
        .prdata_o         (prdata_o),
        .pready_o         (pready_o),
        .perror_o         (perror_o),
        .intr_active_i    (intr_active_i),
        .intr_valid_o     (intr_valid_o),
        .intr_to_service_o(intr_to_service_o),
        .intr_serviced_i  (intr_serviced_i)
    );

    always #5 pclk_i = ~pclk_i;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d exp %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge pclk_i);
        #1;
    endtask

    task automatic apb(input logic w, input logic [1:0] b,
                       input logic [3:0] i, input logic [3:0] d);
        paddr_i   = {b, i};
        pwrite_i  = w;
        pwdata_i  = d;
        penable_i = 1'b1;
        tick();
        penable_i = 1'b0;
        pwrite_i  = 1'b0;
    endtask

    task automatic service();
        intr_serviced_i = 1'b1;
        tick();
        intr_serviced_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        prst_i          = 1'b0;
        paddr_i         = '0;
        pwrite_i        = 1'b0;
        penable_i       = 1'b0;
        pwdata_i        = '0;
        intr_active_i   = '0;
        intr_serviced_i = 1'b0;
        #1;
        check("rst_pready", pready_o, 0);
        check("rst_perror", perror_o, 0);
        check("rst_prdata", prdata_o, 0);
        check("rst_valid", intr_valid_o, 0);
        check("rst_svc", intr_to_service_o, 0);
        repeat (2) tick();
        prst_i = 1'b1;
        tick();

        // register write/read
        apb(1, 2'b00, 4'd3, 4'd9);
        check("wr_pready", pready_o, 1);
        check("wr_perror", perror_o, 0);
        tick();
        check("idle_pready", pready_o, 0);
        apb(0, 2'b00, 4'd3, 4'd0);
        check("rd_pready", pready_o, 1);
        check("rd_prio3", prdata_o, 9);
        check("rd_perror", perror_o, 0);

        // nonexistent index
        apb(1, 2'b00, 4'd13, 4'd5);
        check("err_perror", perror_o, 1);
        check("err_pready", pready_o, 1);
        check("err_prdata", prdata_o, 0);
        apb(0, 2'b00, 4'd3, 4'd0);
        check("err_noalias", prdata_o, 9);
        check("ok_perror", perror_o, 0);
        apb(1, 2'b01, 4'd0, 4'd0);
        check("prdata_hold", prdata_o, 9);
        apb(1, 2'b01, 4'd7, 4'd1);
        apb(0, 2'b01, 4'd7, 4'd0);
        check("rd_en_zext", prdata_o, 1);
        apb(1, 2'b01, 4'd7, 4'd0);

        // level sources 2 and 5, equal priority
        apb(1, 2'b00, 4'd2, 4'd7);
        apb(1, 2'b00, 4'd5, 4'd7);
        apb(1, 2'b01, 4'd2, 4'd1);
        apb(1, 2'b01, 4'd5, 4'd1);
        intr_active_i[2] = 1'b1;
        intr_active_i[5] = 1'b1;
        tick();
        check("lat_e1", intr_valid_o, 0);
        tick();
        check("lat_e2", intr_valid_o, 0);
        tick();
        check("lat_e3_valid", intr_valid_o, 1);
        check("tie_low_idx", intr_to_service_o, 2);
        apb(1, 2'b00, 4'd5, 4'd15);
        check("wait_stable_svc", intr_to_service_o, 2);
        check("wait_stable_vld", intr_valid_o, 1);
        intr_active_i[2] = 1'b0;
        service();
        check("svc_clr_valid", intr_valid_o, 0);
        check("svc_clr_idx", intr_to_service_o, 0);
        tick();
        check("b2b_valid", intr_valid_o, 1);
        check("b2b_idx", intr_to_service_o, 5);
        intr_active_i[5] = 1'b0;
        service();
        check("last_svc_vld", intr_valid_o, 0);
        repeat (2) tick();
        check("back_idle", intr_valid_o, 0);

        // higher priority beats lower index
        intr_active_i[2] = 1'b1;
        intr_active_i[5] = 1'b1;
        repeat (3) tick();
        check("prio_win", intr_to_service_o, 5);
        intr_active_i[5] = 1'b0;
        service();
        tick();
        check("prio_next", intr_to_service_o, 2);
        intr_active_i[2] = 1'b0;
        service();
        tick();

        // edge source 4
        apb(1, 2'b10, 4'd4, 4'd1);
        apb(1, 2'b00, 4'd4, 4'd3);
        apb(1, 2'b01, 4'd4, 4'd1);
        intr_active_i[4] = 1'b1;
        tick();
        intr_active_i[4] = 1'b0;
        tick();
        check("edge_e2", intr_valid_o, 0);
        tick();
        check("edge_valid", intr_valid_o, 1);
        check("edge_idx", intr_to_service_o, 4);
        apb(0, 2'b11, 4'd4, 4'd0);
        check("edge_pend1", prdata_o, 1);
        service();
        check("edge_svc_vld", intr_valid_o, 0);
        apb(0, 2'b11, 4'd4, 4'd0);
        check("edge_pend_clr", prdata_o, 0);
        intr_active_i[4] = 1'b1;
        tick();
        intr_active_i[4] = 1'b0;
        repeat (2) tick();
        check("edge2_idx", intr_to_service_o, 4);
        intr_serviced_i  = 1'b1;
        intr_active_i[4] = 1'b1;
        tick();
        intr_serviced_i  = 1'b0;
        intr_active_i[4] = 1'b0;
        check("setwin_vld0", intr_valid_o, 0);
        apb(0, 2'b11, 4'd4, 4'd0);
        check("setwin_pend", prdata_o, 1);
        tick();
        check("reoffer_vld", intr_valid_o, 1);
        check("reoffer_idx", intr_to_service_o, 4);
        apb(1, 2'b11, 4'd4, 4'd1);
        check("swclr_stable", intr_valid_o, 1);
        service();
        repeat (2) tick();
        check("swclr_idle", intr_valid_o, 0);

        // pending but disabled source 1
        intr_active_i[1] = 1'b1;
        repeat (4) tick();
        check("dis_no_valid", intr_valid_o, 0);
        apb(0, 2'b11, 4'd1, 4'd0);
        check("dis_pend", prdata_o, 1);
        apb(1, 2'b01, 4'd1, 4'd1);
        check("en_e1", intr_valid_o, 0);
        tick();
        check("en_e2", intr_valid_o, 0);
        tick();
        check("en_e3_valid", intr_valid_o, 1);
        check("en_e3_idx", intr_to_service_o, 1);
        intr_active_i[1] = 1'b0;
        service();
        repeat (2) tick();

        // reset during service of source 6
        apb(1, 2'b01, 4'd6, 4'd1);
        intr_active_i[6] = 1'b1;
        repeat (3) tick();
        check("s6_valid", intr_valid_o, 1);
        check("s6_idx", intr_to_service_o, 6);
        #2;
        prst_i = 1'b0;
        #1;
        check("arst_valid", intr_valid_o, 0);
        check("arst_idx", intr_to_service_o, 0);
        check("arst_prdata", prdata_o, 0);
        intr_active_i[6] = 1'b0;
        #1;
        prst_i = 1'b1;
        repeat (3) tick();
        check("post_rst_idle", intr_valid_o, 0);
        intr_active_i[6] = 1'b1;
        repeat (4) tick();
        check("post_rst_noen", intr_valid_o, 0);
        intr_active_i[6] = 1'b0;
        apb(0, 2'b01, 4'd6, 4'd0);
        check("post_rst_en6", prdata_o, 0);
        apb(0, 2'b00, 4'd3, 4'd0);
        check("post_rst_prio3", prdata_o, 0);
        apb(0, 2'b10, 4'd4, 4'd0);
        check("post_rst_edge4", prdata_o, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
